// File: rtl/dma_port_arbiter_if.sv
// rtl/dma_port_arbiter_if.sv - AXI-lite port bundle (AR/R/AW/W/B) shared by requesters and the DMA port
interface dma_port_arbiter_if;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   modport master (
      output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
   );

   modport slave (
      input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/dma_port_arbiter.sv
// rtl/dma_port_arbiter.sv - two-requester AXI-lite arbiter onto one in-order DMA port
// DMA_ARB_FIXED_PRIO_EN: requester 1 always wins instead of round-robin
module dma_port_arbiter_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset_l,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic empty,
   output logic full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
endmodule

module dma_port_arbiter #(
   parameter int MAX_OUTST = 4
) (
   input  logic              clk,
   input  logic              reset_l,
   dma_port_arbiter_if.slave  rq0,
   dma_port_arbiter_if.slave  rq1,
   dma_port_arbiter_if.master d
);
   logic r_head, r_empty, r_full, r_pop, r_rdy;
   logic w_head, w_empty, w_full, w_pop, w_go;
   logic b_head, b_empty, b_full, b_pop, b_rdy;
   logic ar_lock, ar_lock_src, ar_pick, ar_src, ar_go, ar_hs;
   logic aw_lock, aw_lock_src, aw_pick, aw_src, aw_go, aw_hs;

`ifdef DMA_ARB_FIXED_PRIO_EN
   assign ar_pick = rq1.arvalid;
   assign aw_pick = rq1.awvalid;
`else
   logic ar_last, aw_last;

   assign ar_pick = (rq0.arvalid & rq1.arvalid) ? ~ar_last : rq1.arvalid;
   assign aw_pick = (rq0.awvalid & rq1.awvalid) ? ~aw_last : rq1.awvalid;

   // last resets to 1 so requester 0 takes the first contended grant
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         ar_last <= 1'b1;
         aw_last <= 1'b1;
      end else begin
         if (ar_hs) ar_last <= ar_src;
         if (aw_hs) aw_last <= aw_src;
      end
   end
`endif

   // A stalled grant stays locked so the offered address cannot change under it
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         ar_lock     <= 1'b0;
         ar_lock_src <= 1'b0;
         aw_lock     <= 1'b0;
         aw_lock_src <= 1'b0;
      end else begin
         if (ar_hs) begin
            ar_lock <= 1'b0;
         end else if (ar_go) begin
            ar_lock     <= 1'b1;
            ar_lock_src <= ar_src;
         end
         if (aw_hs) begin
            aw_lock <= 1'b0;
         end else if (aw_go) begin
            aw_lock     <= 1'b1;
            aw_lock_src <= aw_src;
         end
      end
   end

   assign ar_src      = ar_lock ? ar_lock_src : ar_pick;
   assign ar_go       = (ar_src ? rq1.arvalid : rq0.arvalid) & ~r_full & reset_l;
   assign ar_hs       = ar_go & d.arready;
   assign d.arvalid   = ar_go;
   assign d.araddr    = ar_src ? rq1.araddr : rq0.araddr;
   assign rq0.arready = ar_hs & ~ar_src;
   assign rq1.arready = ar_hs & ar_src;

   assign aw_src      = aw_lock ? aw_lock_src : aw_pick;
   assign aw_go       = (aw_src ? rq1.awvalid : rq0.awvalid) & ~(w_full | b_full) & reset_l;
   assign aw_hs       = aw_go & d.awready;
   assign d.awvalid   = aw_go;
   assign d.awaddr    = aw_src ? rq1.awaddr : rq0.awaddr;
   assign rq0.awready = aw_hs & ~aw_src;
   assign rq1.awready = aw_hs & aw_src;

   // Responses carry no ID; the tracking FIFO head is the only routing information
   assign r_rdy      = (r_head ? rq1.rready : rq0.rready) & ~r_empty & reset_l;
   assign d.rready   = r_rdy;
   assign rq0.rvalid = d.rvalid & ~r_empty & ~r_head & reset_l;
   assign rq1.rvalid = d.rvalid & ~r_empty & r_head & reset_l;
   assign r_pop      = d.rvalid & r_rdy & d.rlast;
   assign rq0.rdata  = d.rdata;
   assign rq1.rdata  = d.rdata;
   assign rq0.rresp  = d.rresp;
   assign rq1.rresp  = d.rresp;
   assign rq0.rlast  = d.rlast;
   assign rq1.rlast  = d.rlast;

   assign w_go       = (w_head ? rq1.wvalid : rq0.wvalid) & ~w_empty & reset_l;
   assign d.wvalid   = w_go;
   assign d.wdata    = w_head ? rq1.wdata : rq0.wdata;
   assign d.wstrb    = w_head ? rq1.wstrb : rq0.wstrb;
   assign rq0.wready = d.wready & ~w_empty & ~w_head & reset_l;
   assign rq1.wready = d.wready & ~w_empty & w_head & reset_l;
   assign w_pop      = w_go & d.wready;

   assign b_rdy      = (b_head ? rq1.bready : rq0.bready) & ~b_empty & reset_l;
   assign d.bready   = b_rdy;
   assign rq0.bvalid = d.bvalid & ~b_empty & ~b_head & reset_l;
   assign rq1.bvalid = d.bvalid & ~b_empty & b_head & reset_l;
   assign b_pop      = d.bvalid & b_rdy;
   assign rq0.bresp  = d.bresp;
   assign rq1.bresp  = d.bresp;

   dma_port_arbiter_fifo #(.DEPTH(MAX_OUTST)) u_r_fifo (
      .clk(clk), .reset_l(reset_l), .push(ar_hs), .din(ar_src), .pop(r_pop),
      .dout(r_head), .empty(r_empty), .full(r_full)
   );

   dma_port_arbiter_fifo #(.DEPTH(MAX_OUTST)) u_w_fifo (
      .clk(clk), .reset_l(reset_l), .push(aw_hs), .din(aw_src), .pop(w_pop),
      .dout(w_head), .empty(w_empty), .full(w_full)
   );

   dma_port_arbiter_fifo #(.DEPTH(MAX_OUTST)) u_b_fifo (
      .clk(clk), .reset_l(reset_l), .push(aw_hs), .din(aw_src), .pop(b_pop),
      .dout(b_head), .empty(b_empty), .full(b_full)
   );
endmodule

// File: tb/tb_dma_port_arbiter.sv
// tb/tb_dma_port_arbiter.sv - scoreboard bench for dma_port_arbiter
module tb_dma_port_arbiter;
`ifdef DMA_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct {
      logic        src;
      logic [63:0] val;
      logic [7:0]  strb;
   } exp_t;

   logic clk = 1'b0;
   logic reset_l;
   int   checks = 0;
   int   failures = 0;
   exp_t ar_q[$], r_q[$], aw_q[$], w_q[$], b_q[$];
   exp_t m_e;
   logic first;

   always #5 clk = ~clk;

   dma_port_arbiter_if rq0();
   dma_port_arbiter_if rq1();
   dma_port_arbiter_if dm();

   dma_port_arbiter #(.MAX_OUTST(4)) dut (
      .clk(clk), .reset_l(reset_l), .rq0(rq0), .rq1(rq1), .d(dm)
   );

   function automatic exp_t mk(input logic src, input logic [63:0] val, input logic [7:0] strb);
      exp_t e;
      e.src  = src;
      e.val  = val;
      e.strb = strb;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [14:0] hs_outs();
      return {dm.arvalid, dm.rready, dm.awvalid, dm.wvalid, dm.bready,
              rq0.arready, rq0.rvalid, rq0.awready, rq0.wready, rq0.bvalid,
              rq1.arready, rq1.rvalid, rq1.awready, rq1.wready, rq1.bvalid};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Monitor: every handshake the DUT presents is matched against the next queued expectation
   always @(negedge clk) begin
      if (reset_l) begin
         if (dm.arvalid && dm.arready) begin
            if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
               m_e = ar_q.pop_front();
               check("ar_grant", {rq1.arready, rq0.arready}, m_e.src ? 2'b10 : 2'b01);
               check("ar_addr", dm.araddr, m_e.val);
            end
         end
         if ((rq0.rvalid && rq0.rready) || (rq1.rvalid && rq1.rready)) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
               m_e = r_q.pop_front();
               check("r_dest", {rq1.rvalid, rq0.rvalid}, m_e.src ? 2'b10 : 2'b01);
               check("r_data", rq1.rvalid ? rq1.rdata : rq0.rdata, m_e.val);
            end
         end
         if (dm.awvalid && dm.awready) begin
            if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
            else begin
               m_e = aw_q.pop_front();
               check("aw_grant", {rq1.awready, rq0.awready}, m_e.src ? 2'b10 : 2'b01);
               check("aw_addr", dm.awaddr, m_e.val);
            end
         end
         if (dm.wvalid && dm.wready) begin
            if (w_q.size() == 0) check("w_unexpected", 1, 0);
            else begin
               m_e = w_q.pop_front();
               check("w_src", {rq1.wready, rq0.wready}, m_e.src ? 2'b10 : 2'b01);
               check("w_data", dm.wdata, m_e.val);
               check("w_strb", dm.wstrb, m_e.strb);
            end
         end
         if ((rq0.bvalid && rq0.bready) || (rq1.bvalid && rq1.bready)) begin
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else begin
               m_e = b_q.pop_front();
               check("b_dest", {rq1.bvalid, rq0.bvalid}, m_e.src ? 2'b10 : 2'b01);
               check("b_resp", rq1.bvalid ? rq1.bresp : rq0.bresp, m_e.val);
            end
         end
      end
   end

   initial begin
      reset_l = 1'b0;
      rq0.arvalid = 0; rq0.araddr = 0; rq0.rready = 1; rq0.awvalid = 0; rq0.awaddr = 0;
      rq0.wvalid = 0; rq0.wdata = 0; rq0.wstrb = 0; rq0.bready = 1;
      rq1.arvalid = 0; rq1.araddr = 0; rq1.rready = 1; rq1.awvalid = 0; rq1.awaddr = 0;
      rq1.wvalid = 0; rq1.wdata = 0; rq1.wstrb = 0; rq1.bready = 1;
      dm.arready = 0; dm.rvalid = 0; dm.rdata = 0; dm.rresp = 0; dm.rlast = 0;
      dm.awready = 0; dm.wready = 0; dm.bvalid = 0; dm.bresp = 0;
      step(); step();
      at_neg();
      check("reset_outs", hs_outs(), 15'h0);
      step();
      reset_l = 1'b1;
      step();

      // Simultaneous reads: round-robin starts with rq0 (fixed priority: rq1)
      first = FIXED;
      dm.arready = 1;
      rq0.arvalid = 1; rq0.araddr = 32'h100;
      rq1.arvalid = 1; rq1.araddr = 32'h200;
      ar_q.push_back(mk(first, first ? 64'h200 : 64'h100, 0));
      ar_q.push_back(mk(!first, first ? 64'h100 : 64'h200, 0));
      step();
      rq0.arvalid = first; rq1.arvalid = !first;
      step();
      rq0.arvalid = 0; rq1.arvalid = 0;
      dm.rvalid = 1; dm.rlast = 0; dm.rdata = 64'hA0;
      r_q.push_back(mk(first, 64'hA0, 0));
      step();
      dm.rlast = 1; dm.rdata = 64'hA1;
      r_q.push_back(mk(first, 64'hA1, 0));
      step();
      dm.rdata = 64'hA2;
      r_q.push_back(mk(!first, 64'hA2, 0));
      step();
      dm.rvalid = 0;

      // Single rq0 read leaves last=0, so only the lock can keep rq0 granted below
      rq0.arvalid = 1; rq0.araddr = 32'h300;
      ar_q.push_back(mk(0, 64'h300, 0));
      step();
      rq0.arvalid = 0;
      dm.rvalid = 1; dm.rdata = 64'hA3;
      r_q.push_back(mk(0, 64'hA3, 0));
      step();
      dm.rvalid = 0;

      // Stall/lock
      dm.arready = 0;
      rq0.arvalid = 1; rq0.araddr = 32'h1000;
      ar_q.push_back(mk(0, 64'h1000, 0));
      at_neg();
      check("stall_addr0", dm.araddr, 32'h1000);
      step();
      rq1.arvalid = 1; rq1.araddr = 32'h2000;
      ar_q.push_back(mk(1, 64'h2000, 0));
      at_neg();
      check("stall_addr1", dm.araddr, 32'h1000);
      step();
      at_neg();
      check("stall_addr2", dm.araddr, 32'h1000);
      step();
      dm.arready = 1;
      step();
      rq0.arvalid = 0;
      step();
      rq1.arvalid = 0;
      dm.rvalid = 1; dm.rdata = 64'hB0;
      r_q.push_back(mk(0, 64'hB0, 0));
      step();
      dm.rdata = 64'hB1;
      r_q.push_back(mk(1, 64'hB1, 0));
      step();
      dm.rvalid = 0;

      // Read FIFO full
      rq0.arvalid = 1;
      for (int i = 0; i < 4; i++) begin
         rq0.araddr = 32'h4000 + 32'(i * 4);
         ar_q.push_back(mk(0, 64'h4000 + 64'(i * 4), 0));
         step();
      end
      rq0.araddr = 32'h4010;
      ar_q.push_back(mk(0, 64'h4010, 0));
      dm.rvalid = 1; dm.rdata = 64'hC0;
      r_q.push_back(mk(0, 64'hC0, 0));
      at_neg();
      check("full_arready", rq0.arready, 0);
      check("full_d_arvalid", dm.arvalid, 0);
      step();
      dm.rvalid = 0;
      at_neg();
      check("after_pop_d_arvalid", dm.arvalid, 1);
      step();
      rq0.arvalid = 0;
      dm.rvalid = 1;
      for (int i = 1; i < 5; i++) begin
         dm.rdata = 64'hC0 + 64'(i);
         r_q.push_back(mk(0, 64'hC0 + 64'(i), 0));
         step();
      end
      dm.rvalid = 0;

      // Interleaved writes: rq0 offers W before its AW
      dm.awready = 1; dm.wready = 1;
      rq1.awvalid = 1; rq1.awaddr = 32'h3000;
      aw_q.push_back(mk(1, 64'h3000, 0));
      rq0.wvalid = 1; rq0.wdata = 64'hD0D0; rq0.wstrb = 8'h0F;
      at_neg();
      check("w_early0", rq0.wready, 0);
      step();
      rq1.awvalid = 0;
      rq0.awvalid = 1; rq0.awaddr = 32'h4000;
      aw_q.push_back(mk(0, 64'h4000, 0));
      at_neg();
      check("w_early1", rq0.wready, 0);
      step();
      rq0.awvalid = 0;
      rq1.wvalid = 1; rq1.wdata = 64'hD1D1; rq1.wstrb = 8'hFF;
      w_q.push_back(mk(1, 64'hD1D1, 8'hFF));
      at_neg();
      check("w_early2", rq0.wready, 0);
      step();
      rq1.wvalid = 0;
      w_q.push_back(mk(0, 64'hD0D0, 8'h0F));
      step();
      rq0.wvalid = 0;
      dm.bvalid = 1; dm.bresp = 2'b00;
      b_q.push_back(mk(1, 64'h0, 0));
      step();
      dm.bresp = 2'b10;
      b_q.push_back(mk(0, 64'h2, 0));
      step();
      dm.bvalid = 0;

      // Spurious response with empty B FIFO
      dm.bvalid = 1; dm.bresp = 2'b01;
      at_neg();
      check("spur_bready", dm.bready, 0);
      check("spur_bvalid", {rq1.bvalid, rq0.bvalid}, 2'b00);
      step();
      dm.bvalid = 0;

      // Reset with two reads outstanding (last=0 here, so rq1 goes first either way)
      rq0.arvalid = 1; rq0.araddr = 32'h5000;
      rq1.arvalid = 1; rq1.araddr = 32'h6000;
      ar_q.push_back(mk(1, 64'h6000, 0));
      ar_q.push_back(mk(0, 64'h5000, 0));
      step();
      rq1.arvalid = 0;
      step();
      rq0.arvalid = 0;
      reset_l = 0;
      rq0.arvalid = 1; rq0.araddr = 32'h5100;
      rq1.arvalid = 1; rq1.araddr = 32'h6100;
      rq1.awvalid = 1; rq0.wvalid = 1;
      dm.rvalid = 1; dm.rlast = 1; dm.bvalid = 1;
      at_neg();
      check("reset_mid_outs", hs_outs(), 15'h0);
      step(); step();
      rq1.awvalid = 0; rq0.wvalid = 0; dm.bvalid = 0;
      reset_l = 1;
      first = FIXED;
      ar_q.push_back(mk(first, first ? 64'h6100 : 64'h5100, 0));
      ar_q.push_back(mk(!first, first ? 64'h5100 : 64'h6100, 0));
      at_neg();
      check("post_reset_rready", dm.rready, 0);
      check("post_reset_rvalid", {rq1.rvalid, rq0.rvalid}, 2'b00);
      step();
      dm.rvalid = 0;
      rq0.arvalid = first; rq1.arvalid = !first;
      step();
      rq0.arvalid = 0; rq1.arvalid = 0;
      dm.rvalid = 1; dm.rdata = 64'hE0;
      r_q.push_back(mk(first, 64'hE0, 0));
      step();
      dm.rdata = 64'hE1;
      r_q.push_back(mk(!first, 64'hE1, 0));
      step();
      dm.rvalid = 0;
      step(); step(); step();

      check("ar_q_drained", ar_q.size(), 0);
      check("r_q_drained", r_q.size(), 0);
      check("aw_q_drained", aw_q.size(), 0);
      check("w_q_drained", w_q.size(), 0);
      check("b_q_drained", b_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
